// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low {g,f,e,d,c,b,a} glyphs and
// the scan FSM state encoding.
package seg_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  typedef enum logic {
    ST_DARK = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment glyph; codes 10..15
// render as a dash so corrupt counter values are visible on the display.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_digit)
      4'd0: o_seg = SEG_0;
      4'd1: o_seg = SEG_1;
      4'd2: o_seg = SEG_2;
      4'd3: o_seg = SEG_3;
      4'd4: o_seg = SEG_4;
      4'd5: o_seg = SEG_5;
      4'd6: o_seg = SEG_6;
      4'd7: o_seg = SEG_7;
      4'd8: o_seg = SEG_8;
      4'd9: o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed common-anode display driver: snapshots the BCD digits once per
// frame and lights one digit at a time for PRESCALE cycles each.
module seven_seg_scan
  import seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 100000
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic                  frame,
  output logic                  dbg_state
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(PRESCALE);

  scan_state_t           r_state;
  logic [PRE_W-1:0]      r_pre;
  logic [IDX_W-1:0]      r_idx;
  logic [4*DIGITS-1:0]   r_snap_bcd;
  logic [DIGITS-1:0]     r_snap_dp;
  logic [DIGITS-1:0]     r_an;
  logic [6:0]            r_seg;
  logic                  r_dp_n;
  logic                  r_frame;

  logic                  w_pre_last;
  logic                  w_idx_last;
  logic [DIGITS-1:0]     w_an_n;
  logic [3:0]            w_digit;
  logic                  w_dp;
  logic                  w_blank_sel;
  logic [DIGITS-1:0]     w_blank;
  logic                  w_blanked;
  logic [6:0]            w_seg;

  assign w_pre_last = (r_pre == PRE_W'(PRESCALE - 1));
  assign w_idx_last = (r_idx == IDX_W'(DIGITS - 1));

  // Select the current digit's glyph source, dp and blank flag from the snapshot.
  always_comb begin
    w_an_n      = '1;
    w_digit     = 4'd0;
    w_dp        = 1'b0;
    w_blank_sel = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_an_n[k]   = 1'b0;
        w_digit     = r_snap_bcd[4*k +: 4];
        w_dp        = r_snap_dp[k];
        w_blank_sel = w_blank[k];
      end
    end
  end

  // A digit is a leading zero when it and every more-significant digit are
  // zero with no decimal point requested; digit 0 always stays lit.
  always_comb begin
    logic v_zero_above;
    v_zero_above = 1'b1;
    w_blank      = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      v_zero_above = v_zero_above & (r_snap_bcd[4*k +: 4] == 4'd0) & ~r_snap_dp[k];
      w_blank[k]   = (k != 0) && v_zero_above;
    end
  end

  assign w_blanked = blank_lz & w_blank_sel;

  bcd_to_seg u_bcd_to_seg (
    .i_digit (w_digit),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state    <= ST_DARK;
      r_pre      <= '0;
      r_idx      <= '0;
      r_snap_bcd <= '0;
      r_snap_dp  <= '0;
      r_frame    <= 1'b0;
      r_an       <= '1;
      r_seg      <= SEG_OFF;
      r_dp_n     <= 1'b1;
    end else begin
      case (r_state)
        ST_DARK: begin
          r_pre <= '0;
          r_idx <= '0;
          if (en) begin
            r_state    <= ST_SCAN;
            r_snap_bcd <= bcd;
            r_snap_dp  <= dp;
            r_frame    <= 1'b1;
          end else begin
            r_frame    <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (!en) begin
            r_state <= ST_DARK;
            r_pre   <= '0;
            r_idx   <= '0;
            r_frame <= 1'b0;
          end else if (w_pre_last) begin
            r_pre <= '0;
            if (w_idx_last) begin
              r_idx      <= '0;
              r_snap_bcd <= bcd;
              r_snap_dp  <= dp;
              r_frame    <= 1'b1;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_frame <= 1'b0;
            end
          end else begin
            r_pre   <= r_pre + PRE_W'(1);
            r_frame <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_DARK;
          r_frame <= 1'b0;
        end
      endcase

      // Display outputs follow the state/index/snapshot of the previous cycle.
      if (r_state == ST_SCAN && !w_blanked) begin
        r_an   <= w_an_n;
        r_seg  <= w_seg;
        r_dp_n <= ~w_dp;
      end else begin
        r_an   <= '1;
        r_seg  <= SEG_OFF;
        r_dp_n <= 1'b1;
      end
    end
  end

  assign an        = r_an;
  assign seg       = r_seg;
  assign dp_n      = r_dp_n;
  assign frame     = r_frame;
  assign dbg_state = (r_state == ST_SCAN);

endmodule
